// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: ID-stage load-use stall, branch flush and dmem-busy freeze controller.
// Ports: clk/rst (sync, active-high); load-use inputs id_ex_mem_read, id_ex_rt_addr,
// if_id_rs_addr, if_id_rt_addr, if_id_uses_rt; branch_taken; dmem_busy.
// Outputs: pipeline register enables pc_write, if_id_write, id_ex_write, ex_mem_write,
// if_id_flush, id_ex_bubble, plus hazard and stall_cnt (remaining stall cycles).
// Optional: define HAZ_PERF_CNT_EN to add perf_clr / perf_stall_cycles stall-cycle counter.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rt_addr,
  input  logic [REG_AW-1:0] if_id_rs_addr,
  input  logic [REG_AW-1:0] if_id_rt_addr,
  input  logic              if_id_uses_rt,
  input  logic              branch_taken,
  input  logic              dmem_busy,
`ifdef HAZ_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [15:0]       perf_stall_cycles,
`endif
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              hazard,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [CNT_W-1:0] LS = CNT_W'(LOAD_STALL);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             detect, stalled, run_det;
  assign detect = id_ex_mem_read && id_ex_rt_addr != '0 &&
                  (id_ex_rt_addr == if_id_rs_addr || (if_id_uses_rt && id_ex_rt_addr == if_id_rt_addr));
  // A detect seen during a freeze is not acted on until dmem_busy drops, so in RUN
  // the hazard only shows once the pipe is moving; in STALL it persists through a freeze.
  always_comb begin
    stalled      = state == STALL;
    run_det      = state == RUN && detect && !dmem_busy;
    hazard       = stalled || run_det;
    stall_cnt    = stalled ? cnt : run_det ? LS : '0;
    pc_write     = !dmem_busy && !hazard;
    if_id_write  = !dmem_busy && !hazard;
    id_ex_bubble = !dmem_busy && hazard;
    id_ex_write  = !dmem_busy;
    ex_mem_write = !dmem_busy;
    if_id_flush  = branch_taken && !hazard && !dmem_busy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!dmem_busy) begin
      if (stalled) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) state <= RUN;
      end else if (detect && LOAD_STALL > 1) begin
        state <= STALL;
        cnt   <= LS - 1'b1;
      end
    end
  end
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk)
    perf_stall_cycles <= (rst || perf_clr) ? '0 :
                         (hazard && !dmem_busy && perf_stall_cycles != 16'hFFFF) ? perf_stall_cycles + 16'd1 :
                         perf_stall_cycles;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed self-checking bench for hazard_ctrl_unit at LOAD_STALL 1, 3 and 4.
module tb_hazard_ctrl_unit;
  localparam logic [9:0] NORM  = 10'b1111000000;
  localparam logic [9:0] FLUSH = 10'b1111100000;
  localparam logic [9:0] FRZ   = 10'b0000000000;
  logic clk = 1'b0;
  logic rst = 1'b0, perf_clr = 1'b0;
  logic mr = 1'b0, urt = 1'b0, br = 1'b0, busy = 1'b0;
  logic [4:0] ex_rt = '0, rs = '0, rt = '0;
  logic [2:0] pw, iw, ew, mw, fl, bb, hz;
  logic [2:0] sc [3];
  logic [15:0] pf [3];
  logic [9:0] v [3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  // Output vector: {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_bubble, hazard, stall_cnt}
  always_comb for (int i = 0; i < 3; i++) v[i] = {pw[i], iw[i], ew[i], mw[i], fl[i], bb[i], hz[i], sc[i]};
  function automatic logic [9:0] stl(input logic [2:0] n);
    return {7'b0011011, n};
  endfunction
  function automatic logic [9:0] frz(input logic [2:0] n);
    return {7'b0000001, n};
  endfunction
  hazard_ctrl_unit #(.LOAD_STALL(1)) u1 (
    .clk(clk), .rst(rst), .id_ex_mem_read(mr), .id_ex_rt_addr(ex_rt), .if_id_rs_addr(rs),
    .if_id_rt_addr(rt), .if_id_uses_rt(urt), .branch_taken(br), .dmem_busy(busy),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_stall_cycles(pf[0]),
`endif
    .pc_write(pw[0]), .if_id_write(iw[0]), .if_id_flush(fl[0]), .id_ex_bubble(bb[0]),
    .id_ex_write(ew[0]), .ex_mem_write(mw[0]), .hazard(hz[0]), .stall_cnt(sc[0]));
  hazard_ctrl_unit #(.LOAD_STALL(3)) u3 (
    .clk(clk), .rst(rst), .id_ex_mem_read(mr), .id_ex_rt_addr(ex_rt), .if_id_rs_addr(rs),
    .if_id_rt_addr(rt), .if_id_uses_rt(urt), .branch_taken(br), .dmem_busy(busy),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_stall_cycles(pf[1]),
`endif
    .pc_write(pw[1]), .if_id_write(iw[1]), .if_id_flush(fl[1]), .id_ex_bubble(bb[1]),
    .id_ex_write(ew[1]), .ex_mem_write(mw[1]), .hazard(hz[1]), .stall_cnt(sc[1]));
  hazard_ctrl_unit #(.LOAD_STALL(4)) u4 (
    .clk(clk), .rst(rst), .id_ex_mem_read(mr), .id_ex_rt_addr(ex_rt), .if_id_rs_addr(rs),
    .if_id_rt_addr(rt), .if_id_uses_rt(urt), .branch_taken(br), .dmem_busy(busy),
`ifdef HAZ_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_stall_cycles(pf[2]),
`endif
    .pc_write(pw[2]), .if_id_write(iw[2]), .if_id_flush(fl[2]), .id_ex_bubble(bb[2]),
    .id_ex_write(ew[2]), .ex_mem_write(mw[2]), .hazard(hz[2]), .stall_cnt(sc[2]));
`ifndef HAZ_PERF_CNT_EN
  initial for (int i = 0; i < 3; i++) pf[i] = '0;
`endif
  // Apply one cycle of inputs at the falling edge; outputs are then sampled mid-low-phase.
  task automatic drive(input logic r, input logic pc, input logic m, input logic [4:0] e,
                       input logic [4:0] s, input logic [4:0] t, input logic u, input logic b, input logic d);
    @(negedge clk);
    rst = r; perf_clr = pc; mr = m; ex_rt = e; rs = s; rt = t; urt = u; br = b; busy = d;
    #2;
  endtask
  task automatic idle();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask
  task automatic test_reset();
    do_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (v[i] !== NORM) begin fails++; $display("FAIL reset[%0d]: got %b want %b", i, v[i], NORM); end
    end
`ifdef HAZ_PERF_CNT_EN
    tests++;
    if (pf[1] !== 16'd0) begin fails++; $display("FAIL reset_perf: got %0d want 0", pf[1]); end
`endif
  endtask
  task automatic test_load_stall_1();
    do_reset();
    drive(0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0);
    tests++;
    if (v[0] !== stl(3'd1)) begin fails++; $display("FAIL ls1_stall: got %b want %b", v[0], stl(3'd1)); end
    idle();
    tests++;
    if (v[0] !== NORM) begin fails++; $display("FAIL ls1_resume: got %b want %b", v[0], NORM); end
  endtask
  task automatic test_load_stall_3();
    do_reset();
    drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0);
    tests++;
    if (v[1] !== stl(3'd3)) begin fails++; $display("FAIL ls3_c1: got %b want %b", v[1], stl(3'd3)); end
    for (int n = 2; n >= 1; n--) begin
      idle();
      tests++;
      if (v[1] !== stl(3'(n))) begin fails++; $display("FAIL ls3_c%0d: got %b want %b", 4 - n, v[1], stl(3'(n))); end
    end
    idle();
    tests++;
    if (v[1] !== NORM) begin fails++; $display("FAIL ls3_done: got %b want %b", v[1], NORM); end
  endtask
  task automatic test_no_hazard();
    do_reset();
    drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    tests++;
    if (v[1] !== NORM) begin fails++; $display("FAIL nohaz_r0: got %b want %b", v[1], NORM); end
    drive(0, 0, 1, 5'd4, 5'd1, 5'd4, 0, 0, 0);
    tests++;
    if (v[1] !== NORM) begin fails++; $display("FAIL nohaz_no_rt: got %b want %b", v[1], NORM); end
    drive(0, 0, 0, 5'd4, 5'd4, 5'd4, 1, 0, 0);
    tests++;
    if (v[1] !== NORM) begin fails++; $display("FAIL nohaz_not_load: got %b want %b", v[1], NORM); end
  endtask
  task automatic test_freeze();
    logic [9:0] exp [6];
    exp = '{stl(3'd3), frz(3'd2), frz(3'd2), stl(3'd2), stl(3'd1), NORM};
    do_reset();
    drive(0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, (c == 1 || c == 2));
      tests++;
      if (v[1] !== exp[c]) begin fails++; $display("FAIL freeze_c%0d: got %b want %b", c, v[1], exp[c]); end
    end
`ifdef HAZ_PERF_CNT_EN
    tests++;
    if (pf[1] !== 16'd3) begin fails++; $display("FAIL perf_count: got %0d want 3", pf[1]); end
    drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle();
    tests++;
    if (pf[1] !== 16'd0) begin fails++; $display("FAIL perf_clr: got %0d want 0", pf[1]); end
`endif
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    tests++;
    if (v[1] !== FRZ) begin fails++; $display("FAIL freeze_branch: got %b want %b", v[1], FRZ); end
    drive(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1);
    tests++;
    if (v[1] !== FRZ) begin fails++; $display("FAIL freeze_detect: got %b want %b", v[1], FRZ); end
    drive(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 0);
    tests++;
    if (v[1] !== stl(3'd3)) begin fails++; $display("FAIL detect_after_freeze: got %b want %b", v[1], stl(3'd3)); end
  endtask
  task automatic test_branch();
    do_reset();
    drive(0, 0, 1, 5'd6, 5'd6, 5'd0, 0, 1, 0);
    tests++;
    if (v[0] !== stl(3'd1)) begin fails++; $display("FAIL br_stall_ls1: got %b want %b", v[0], stl(3'd1)); end
    tests++;
    if (v[1] !== stl(3'd3)) begin fails++; $display("FAIL br_stall_ls3: got %b want %b", v[1], stl(3'd3)); end
    drive(0, 0, 0, 5'd0, 5'd6, 5'd0, 0, 1, 0);
    tests++;
    if (v[0] !== FLUSH) begin fails++; $display("FAIL br_flush: got %b want %b", v[0], FLUSH); end
    idle();
    tests++;
    if (v[0] !== NORM) begin fails++; $display("FAIL br_after: got %b want %b", v[0], NORM); end
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    drive(0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    idle();
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    tests++;
    if (v[2] !== stl(3'd2)) begin fails++; $display("FAIL mid_before: got %b want %b", v[2], stl(3'd2)); end
    idle();
    tests++;
    if (v[2] !== NORM) begin fails++; $display("FAIL mid_reset: got %b want %b", v[2], NORM); end
`ifdef HAZ_PERF_CNT_EN
    tests++;
    if (pf[2] !== 16'd0) begin fails++; $display("FAIL mid_perf: got %0d want 0", pf[2]); end
`endif
  endtask
  initial begin
    test_reset();
    test_load_stall_1();
    test_load_stall_3();
    test_no_hazard();
    test_freeze();
    test_branch();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised hazard controller for the 5-stage MIPS pipeline; successor to the purely combinational load-use detector.
- Adds a configurable load-use stall length for multi-cycle data memory, branch/jump IF/ID flush, and a whole-pipe freeze while data memory is busy.
- Sits in the ID stage and drives the write enables of the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- REG_AW, 5, register address width.
- LOAD_STALL, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 3, width of the internal stall counter; must satisfy 2^CNT_W > LOAD_STALL.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt_addr  in  REG_AW  load destination register
- if_id_rs_addr  in  REG_AW  rs of instruction in ID
- if_id_rt_addr  in  REG_AW  rt of instruction in ID
- if_id_uses_rt  in  1  instruction in ID reads rt (R-type, beq/bne, sw)
- branch_taken  in  1  branch resolved taken in ID, or jump
- dmem_busy  in  1  data memory wait state
- pc_write  out  1  1 = PC updates
- if_id_write  out  1  1 = IF/ID loads; 0 = IF/ID holds
- if_id_flush  out  1  1 = IF/ID loads a NOP
- id_ex_bubble  out  1  1 = ID/EX loads zeroed control
- id_ex_write  out  1  1 = ID/EX loads
- ex_mem_write  out  1  1 = EX/MEM loads
- hazard  out  1  a load-use stall is active this cycle
- stall_cnt  out  CNT_W  remaining load-use stall cycles, including the current one

Behaviour:
- Detect (combinational): id_ex_mem_read && id_ex_rt_addr != 0 && (id_ex_rt_addr == if_id_rs_addr || (if_id_uses_rt && id_ex_rt_addr == if_id_rt_addr)). Register 0 never causes a hazard.
- FSM states: RUN, STALL. Outputs are Mealy (state + inputs); state and counter are registered.
- Reset: state=RUN, counter=0.
  - Outputs at reset: pc_write=1, if_id_write=1, id_ex_write=1, ex_mem_write=1, if_id_flush=0, id_ex_bubble=0, hazard=0, stall_cnt=0.
  - Reset mid-stall aborts the stall on the next edge.
- RUN, detect=1:
  - Same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1, hazard=1, stall_cnt=LOAD_STALL.
  - If LOAD_STALL>1: next state STALL, counter=LOAD_STALL-1. Otherwise stay in RUN.
- STALL:
  - Same stall outputs as RUN with detect; stall_cnt=counter.
  - Counter decrements each non-frozen cycle. On counter==1 the next state is RUN.
  - Detect is ignored in STALL; the bubble has already left ID/EX.
- Total bubbles per hazard = exactly LOAD_STALL cycles, excluding freeze cycles.
- Branch: if_id_flush = branch_taken && !hazard && !dmem_busy.
  - A stalled branch must not flush; its operands are stale and it re-resolves after the stall.
  - pc_write is unaffected by the flush; the PC loads the target.
- Freeze: dmem_busy=1 overrides all other outputs.
  - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, id_ex_bubble=0, if_id_flush=0.
  - FSM state and counter hold. hazard and stall_cnt keep their current values.
  - A load-use detect arriving during a freeze is evaluated on the first non-busy cycle.
- Simultaneous detect + branch_taken in RUN: the stall wins, with no flush.
- id_ex_write=1 and ex_mem_write=1 whenever not frozen; a bubble is a load of zeroed control.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cycles [15:0] and input perf_clr [1].
  - The counter increments on every cycle with hazard=1 && !dmem_busy and saturates at 16'hFFFF.
  - perf_clr or rst clears it to 0 on the next edge; perf_clr takes priority over increment.
- Undefined: the ports and the counter are absent; all other behaviour is identical.

Test Plan:
- LOAD_STALL=1, lw $2 in EX, ID rs=2 -> 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, hazard=1, stall_cnt=1; normal flow next cycle.
- LOAD_STALL=3, lw $5 in EX, ID rt=5 with uses_rt=1 -> 3 consecutive bubbles, stall_cnt 3,2,1; state returns to RUN.
- lw $0 in EX, ID rs=0 -> no stall; lw $4 in EX, ID rt=4 with uses_rt=0 -> no stall.
- LOAD_STALL=3, dmem_busy=1 for 2 cycles during the second stall cycle -> all enables 0 for 2 cycles; stall_cnt holds at 2; 3 bubbles total.
- Detect and branch_taken in the same cycle -> if_id_flush=0. branch_taken alone next cycle -> if_id_flush=1 for 1 cycle.
- rst asserted during STALL (LOAD_STALL=4, counter=2) -> next cycle all outputs at reset values. With HAZ_PERF_CNT_EN, perf_stall_cycles=0.
